// File: rtl/rx_interface.sv
// Receive-side metaframe aligner: hunts for sync, verifies spacing, locks, and delivers payload words.
// Optional RX_ERR_COUNT_EN adds a saturating ERR_COUNT of SYNC_ERR/WORD_ERR pulses.
module rx_interface #(
  parameter int META_FRAME_LEN = 16,
  parameter int LOCK_CNT       = 4,
  parameter int LOSS_CNT       = 4
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [63:0] DATA_IN,
  input  logic [1:0]  HEADER_IN,
  input  logic        DATA_IN_VALID,
  output logic [63:0] DATA_OUT,
  output logic        DATA_OUT_VALID,
  output logic        FRAME_LOCK,
  output logic        SYNC_ERR,
  output logic        WORD_ERR
`ifdef RX_ERR_COUNT_EN
  ,
  output logic [15:0] ERR_COUNT
`endif
);

  localparam int PW = $clog2(META_FRAME_LEN);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [63:0] SYNC_WORD = 64'h78f678f678f678f6;
  localparam logic [63:0] IDLE_WORD = 64'hAAAAAAAAAAAAAAAA;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [PW-1:0]   pos_r, pos_nxt_s;
  logic [GW-1:0]   good_cnt_r, good_nxt_s;
  logic [BW-1:0]   bad_cnt_r, bad_nxt_s;
  logic            deliver_s, sync_err_s, word_err_s;
  logic            is_sync_s, is_scrm_s, is_idle_s, is_ctrl_s;

  assign is_ctrl_s = (HEADER_IN == 2'b10);
  assign is_sync_s = is_ctrl_s && (DATA_IN == SYNC_WORD);
  assign is_scrm_s = is_ctrl_s && (DATA_IN[63:56] == 8'h28);
  assign is_idle_s = is_ctrl_s && (DATA_IN == IDLE_WORD);

  // Next-state, position/counter update and per-word classification
  always_comb begin
    state_nxt_s = state_r;
    pos_nxt_s   = pos_r;
    good_nxt_s  = good_cnt_r;
    bad_nxt_s   = bad_cnt_r;
    deliver_s   = 1'b0;
    sync_err_s  = 1'b0;
    word_err_s  = 1'b0;
    if (DATA_IN_VALID) begin
      case (state_r)
        ST_HUNT: begin
          if (is_sync_s) begin
            state_nxt_s = ST_VERIFY;
            pos_nxt_s   = PW'(1);
            good_nxt_s  = GW'(1);
          end else begin
            pos_nxt_s = pos_r;
          end
        end
        ST_VERIFY: begin
          pos_nxt_s = pos_r + PW'(1);
          if (pos_r != PW'(0)) begin
            good_nxt_s = good_cnt_r;
          end else if (is_sync_s) begin
            good_nxt_s = good_cnt_r + GW'(1);
            if (good_cnt_r + GW'(1) == GW'(LOCK_CNT)) begin
              state_nxt_s = ST_LOCKED;
              bad_nxt_s   = BW'(0);
            end else begin
              state_nxt_s = ST_VERIFY;
            end
          end else begin
            state_nxt_s = ST_HUNT;
            sync_err_s  = 1'b1;
          end
        end
        ST_LOCKED: begin
          // Position free-runs while locked; alignment is never adjusted here
          pos_nxt_s = pos_r + PW'(1);
          if (pos_r == PW'(0)) begin
            if (is_sync_s) begin
              bad_nxt_s = BW'(0);
            end else begin
              sync_err_s = 1'b1;
              bad_nxt_s  = bad_cnt_r + BW'(1);
              if (bad_cnt_r + BW'(1) == BW'(LOSS_CNT)) begin
                state_nxt_s = ST_HUNT;
              end else begin
                state_nxt_s = ST_LOCKED;
              end
            end
          end else if (pos_r == PW'(1)) begin
            word_err_s = !is_scrm_s;
          end else if (HEADER_IN == 2'b01) begin
            deliver_s = 1'b1;
          end else begin
            word_err_s = !is_idle_s;
          end
        end
        default: begin
          state_nxt_s = ST_HUNT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      state_r        <= ST_HUNT;
      pos_r          <= PW'(0);
      good_cnt_r     <= GW'(0);
      bad_cnt_r      <= BW'(0);
      DATA_OUT       <= 64'h0;
      DATA_OUT_VALID <= 1'b0;
      FRAME_LOCK     <= 1'b0;
      SYNC_ERR       <= 1'b0;
      WORD_ERR       <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      pos_r          <= pos_nxt_s;
      good_cnt_r     <= good_nxt_s;
      bad_cnt_r      <= bad_nxt_s;
      DATA_OUT_VALID <= deliver_s;
      FRAME_LOCK     <= (state_nxt_s == ST_LOCKED);
      SYNC_ERR       <= sync_err_s;
      WORD_ERR       <= word_err_s;
      if (deliver_s) begin
        DATA_OUT <= DATA_IN;
      end else begin
        DATA_OUT <= DATA_OUT;
      end
    end
  end

`ifdef RX_ERR_COUNT_EN
  // Saturating error tally, one cycle behind the error pulses
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      ERR_COUNT <= 16'h0;
    end else if ((SYNC_ERR || WORD_ERR) && (ERR_COUNT != 16'hFFFF)) begin
      ERR_COUNT <= ERR_COUNT + 16'd1;
    end else begin
      ERR_COUNT <= ERR_COUNT;
    end
  end
`endif

endmodule
